// File: rtl/dmem_access_unit.sv
// Data-memory initiator: takes one load/store request at a time, strobes the
// memory for a single cycle, waits out the read latency and returns the response.
module dmem_access_unit #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_en_o,
    output logic              mem_read_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic [1:0]        state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and a response stays stable until taken.

    localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              out_of_range;

    assign out_of_range = {1'b0, req_addr_i} >= DEPTH_C;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d = req_we_i;
                    if (out_of_range) begin
                        // Out-of-range requests never reach the memory pins.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        addr_d  = req_addr_i;
                        wdata_d = req_wdata_i;
                        err_d   = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (RD_LAT == 0) begin
                    rdata_d = we_q ? wdata_q : mem_rdata_i;
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d = we_q ? wdata_q : mem_rdata_i;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign req_ready_o = (state_q == IDLE) && rst_n;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign mem_en_o    = (state_q == ISSUE);
    assign mem_read_o  = (state_q == ISSUE) ? ~we_q : 1'b1;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != IDLE);
    assign state_o     = state_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: RD_LAT=1 unit with a word[i]=i memory model, plus
// an RD_LAT=0 unit for back-to-back loads against a combinational memory.
module tb_dmem_access_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // RD_LAT=1 unit
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [5:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, mem_en, mem_read, busy;
    logic [15:0] rsp_rdata, mem_wdata, mem_rdata;
    logic [5:0]  mem_addr;
    logic [1:0]  state;

    dmem_access_unit #(.ADDR_W(6), .DATA_W(16), .DEPTH(32), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .mem_en_o(mem_en), .mem_read_o(mem_read), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .busy_o(busy), .state_o(state)
    );

    logic [15:0] mem [0:31];
    initial for (int i = 0; i < 32; i++) mem[i] = 16'(i);
    always @(posedge clk) begin
        if (mem_en && !mem_read) mem[mem_addr[4:0]] <= mem_wdata;
        if (mem_en && mem_read) mem_rdata <= mem[mem_addr[4:0]];
    end

    // RD_LAT=0 unit
    logic        z_req_valid = 1'b0, z_rsp_ready = 1'b1;
    logic [5:0]  z_req_addr = '0;
    logic        z_req_ready, z_rsp_valid, z_rsp_err, z_mem_en, z_mem_read, z_busy;
    logic [15:0] z_rsp_rdata, z_mem_wdata, z_mem_rdata;
    logic [5:0]  z_mem_addr;
    logic [1:0]  z_state;

    dmem_access_unit #(.ADDR_W(6), .DATA_W(16), .DEPTH(32), .RD_LAT(0)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(z_req_valid), .req_ready_o(z_req_ready), .req_we_i(1'b0),
        .req_addr_i(z_req_addr), .req_wdata_i(16'h0000),
        .rsp_valid_o(z_rsp_valid), .rsp_ready_i(z_rsp_ready),
        .rsp_rdata_o(z_rsp_rdata), .rsp_err_o(z_rsp_err),
        .mem_en_o(z_mem_en), .mem_read_o(z_mem_read), .mem_addr_o(z_mem_addr),
        .mem_wdata_o(z_mem_wdata), .mem_rdata_i(z_mem_rdata),
        .busy_o(z_busy), .state_o(z_state)
    );
    assign z_mem_rdata = {10'd0, z_mem_addr};

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];
    logic [16:0] z_exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare {err, rdata} on every response handshake.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got err=%0b data=%h, required no response",
                         rsp_err, rsp_rdata);
            end else if ({rsp_err, rsp_rdata} !== exp_q[0]) begin
                errors++;
                $display("FAIL rsp_data: got %h, required %h", {rsp_err, rsp_rdata}, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (z_rsp_valid && z_rsp_ready) begin
            checks++;
            if (z_exp_q.size() == 0) begin
                errors++;
                $display("FAIL z_rsp_unexpected: got data=%h, required no response", z_rsp_rdata);
            end else if ({z_rsp_err, z_rsp_rdata} !== z_exp_q[0]) begin
                errors++;
                $display("FAIL z_rsp_data: got %h, required %h",
                         {z_rsp_err, z_rsp_rdata}, z_exp_q[0]);
                void'(z_exp_q.pop_front());
            end else begin
                void'(z_exp_q.pop_front());
            end
        end
    end

    int en_cnt = 0, wr_cnt = 0, rd_viol = 0;
    always @(negedge clk) begin
        if (mem_en) en_cnt++;
        if (mem_en && !mem_read) wr_cnt++;
        if (!mem_en && !mem_read) rd_viol++;
    end

    // Drive a request from a falling edge; returns 1 ns after the accept edge.
    task automatic send(input logic we, input logic [5:0] addr, input logic [15:0] wdata,
                        input logic push, input logic [16:0] exp);
        bit ok;
        ok = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        check("req_accept_timeout", 32'(ok), 32'd1);
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy && !z_busy) begin ok = 1; break; end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_outs"}, {rsp_err, mem_en, mem_read, busy, rsp_rdata},
              {4'b0010, 16'h0000});
        check({tag, "_mem_pins"}, {mem_addr, mem_wdata}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within bound");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0, acc1, hs1, acc2;
        bit ok;

        #12 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);

        // Load 5: strobe the cycle after acceptance, response two cycles later.
        send(1'b0, 6'd5, 16'h0, 1'b1, {1'b0, 16'd5});
        @(negedge clk);
        check("ld5_issue", {mem_en, mem_read, busy, 2'b0, mem_addr}, {3'b111, 2'b0, 6'd5});
        check("ld5_no_rsp_issue", 32'(rsp_valid), 32'd0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd10; req_wdata = 16'h1234;
        @(negedge clk);
        check("ld5_wait", {mem_en, mem_read, rsp_valid}, 3'b010);
        check("ld5_ignore_req", 32'(mem_addr), 32'd5);
        req_valid = 1'b0;
        @(negedge clk);
        check("ld5_rsp_valid", 32'(rsp_valid), 32'd1);
        wait_idle("ld5_idle");

        // Store then load back.
        en0 = wr_cnt;
        send(1'b1, 6'd31, 16'hBEEF, 1'b1, {1'b0, 16'hBEEF});
        @(negedge clk);
        check("st31_strobe", {mem_en, mem_read, 10'd0, mem_addr}, {2'b10, 10'd0, 6'd31});
        check("st31_wdata", 32'(mem_wdata), 32'h0000BEEF);
        wait_idle("st31_idle");
        check("st31_one_write", 32'(wr_cnt - en0), 32'd1);
        send(1'b0, 6'd31, 16'h0, 1'b1, {1'b0, 16'hBEEF});
        wait_idle("ld31_idle");

        // Out of range: error response right after accept, memory untouched.
        en0 = en_cnt;
        send(1'b0, 6'd40, 16'h0, 1'b1, {1'b1, 16'h0000});
        check("err40_rsp_valid", {rsp_valid, rsp_err, rsp_rdata}, {2'b11, 16'h0});
        check("err40_no_en", 32'(mem_en), 32'd0);
        wait_idle("err40_idle");
        check("err40_mem_untouched", 32'(en_cnt - en0), 32'd0);
        check("err40_mem_addr_held", 32'(mem_addr), 32'd31);

        // Back-pressure: response held five cycles.
        rsp_ready = 1'b0;
        send(1'b0, 6'd7, 16'h0, 1'b1, {1'b0, 16'd7});
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; break; end
        end
        check("bp_rsp_timeout", 32'(ok), 32'd1);
        en0 = en_cnt;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {rsp_valid, req_ready, rsp_err, rsp_rdata}, {3'b100, 16'd7});
            @(negedge clk);
        end
        check("bp_no_en", 32'(en_cnt - en0), 32'd0);
        rsp_ready = 1'b1;
        wait_idle("bp_idle");

        // Reset during WAIT aborts with no response.
        send(1'b0, 6'd9, 16'h0, 1'b0, 17'h0);
        @(posedge clk);
        #1 check("mid_in_wait", 32'(state), 32'd2);
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        send(1'b0, 6'd3, 16'h0, 1'b1, {1'b0, 16'd3});
        wait_idle("ld3_idle");
        check("read_strobe_only", 32'(rd_viol), 32'd0);

        // RD_LAT=0: back-to-back loads with req_valid held.
        z_exp_q.push_back({1'b0, 16'd1});
        z_exp_q.push_back({1'b0, 16'd2});
        @(negedge clk);
        z_req_valid = 1'b1; z_req_addr = 6'd1;
        acc1 = 0; hs1 = 0; acc2 = 0; ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (z_req_ready) begin acc1 = cyc; ok = 1; break; end
            @(negedge clk);
        end
        check("z_acc1_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1 z_req_addr = 6'd2;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (z_rsp_valid) begin hs1 = cyc; ok = 1; break; end
        end
        check("z_rsp1_timeout", 32'(ok), 32'd1);
        check("z_rsp1_latency", 32'(hs1 - acc1), 32'd2);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (z_req_ready) begin acc2 = cyc; ok = 1; break; end
        end
        check("z_acc2_timeout", 32'(ok), 32'd1);
        check("z_acc2_gap", 32'(acc2 - hs1), 32'd1);
        @(posedge clk);
        #1 z_req_valid = 1'b0;
        wait_idle("z_idle");

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        check("z_sb_leftover", 32'(z_exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
